waveform_gen_dds: RTL and testbench

Parametrised DDS waveform generator; next generation of the fixed 8-bit-phase generator chain. Phase accumulator with run-time tuning word, four wave shapes, gain with saturation, and a mode FSM covering continuous, N-cycle burst and linear frequency sweep. Output is a valid/ready sample stream that feeds the FIR/display path; the generator stalls under backpressure and never drops or repeats samples.

---
 rtl/wavegen_pkg.sv | 49 ++++
 rtl/wave_shape_lut.sv | 48 ++++
 rtl/waveform_gen_dds.sv | 144 ++++++++++++++
 tb/tb_waveform_gen_dds.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavegen_pkg.sv
// Shared types and helpers for the DDS waveform generator: mode/shape enums,
// FSM state, output clamp, quarter-wave sine generator and dither LFSR constants.
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_CONT     = 2'd0,
    MODE_BURST    = 2'd1,
    MODE_SWEEP    = 2'd2,
    MODE_CONT_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic int sat_clamp(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Rational sine approximation over a quarter wave, exact at 0 and full scale.
  // Only ever called with constant arguments, so it folds into ROM contents.
  function automatic int sine_q(input int i, input int n, input int peak);
    longint u;
    longint d;
    u = longint'(i) * longint'(2 * n - i);
    d = 5 * longint'(n) * longint'(n) - u;
    return int'((4 * longint'(peak) * u + d / 2) / d);
  endfunction

endpackage

// File: rtl/wave_shape_lut.sv
// Combinational phase-to-shape mapping for sine (quarter-wave ROM with
// mirror/negate), square, triangle and sawtooth.
module wave_shape_lut
  import wavegen_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LUT_AW = 8
) (
  input  logic [DATA_W-1:0] phase_top,
  input  logic [1:0]        wave_sel,
  output logic [DATA_W-1:0] shape
);

  localparam int N     = 1 << LUT_AW;
  localparam int MAG_W = DATA_W - 1;
  localparam int PEAK  = (1 << (DATA_W - 1)) - 1;

  // N+1 entries so the quarter-wave peak is stored rather than approximated.
  logic [MAG_W-1:0] rom [N+1];

  for (genvar i = 0; i <= N; i++) begin : g_rom
    assign rom[i] = MAG_W'(sine_q(i, N, PEAK));
  end

  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [LUT_AW:0]   addr;
  logic [MAG_W-1:0]  mag;
  logic [MAG_W-1:0]  fold;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    shape = '0;
    quad  = phase_top[DATA_W-1 -: 2];
    idx   = phase_top[DATA_W-3 -: LUT_AW];
    addr  = quad[0] ? ({1'b1, {LUT_AW{1'b0}}} - {1'b0, idx}) : {1'b0, idx};
    mag   = rom[addr];
    fold  = phase_top[DATA_W-1] ? ~phase_top[MAG_W-1:0] : phase_top[MAG_W-1:0];
    case (wave_e'(wave_sel))
      WAVE_SINE:     shape = quad[1] ? -{1'b0, mag} : {1'b0, mag};
      WAVE_SQUARE:   shape = phase_top[DATA_W-1] ? {1'b1, {MAG_W{1'b0}}} : {1'b0, {MAG_W{1'b1}}};
      WAVE_TRIANGLE: shape = {~fold[MAG_W-1], fold[MAG_W-2:0], 1'b0};
      WAVE_SAW:      shape = {~phase_top[DATA_W-1], phase_top[MAG_W-1:0]};
      default:       shape = '0;
    endcase
  end

endmodule

// File: rtl/waveform_gen_dds.sv
// DDS waveform generator: phase accumulator, gain/saturation, continuous/burst/sweep
// mode FSM and valid/ready output. Optional shape-lookup dither: WAVEGEN_PHASE_DITHER_EN.
module waveform_gen_dds
  import wavegen_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] ftw_start,
  input  logic [PHASE_W-1:0] ftw_end,
  input  logic [PHASE_W-1:0] ftw_step,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [3:0]         amp,
  input  logic               sample_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  wave_out,
  output logic               busy,
  output logic               done
);

  localparam int PROD_W = DATA_W + 5;

  state_e             state, state_n;
  mode_e              cfg_mode;
  logic [1:0]         cfg_wave;
  logic [PHASE_W-1:0] cfg_end, cfg_step;
  logic [BURST_W-1:0] cfg_len, eff_len, wrap_cnt;
  logic [3:0]         cfg_amp;
  logic [PHASE_W-1:0] phase, ftw, ftw_next, look_phase;
  logic [PHASE_W:0]   phase_sum, ftw_sum;
  logic               advance, wrap, burst_last, sweep_last, terminate, done_n;
  logic [DATA_W-1:0]  shape, gained;
  logic signed [PROD_W-1:0] product, scaled;

  assign advance    = (state == ST_RUN) && sample_en && (!out_valid || out_ready);
  assign phase_sum  = {1'b0, phase} + {1'b0, ftw};
  assign wrap       = advance && phase_sum[PHASE_W];
  assign eff_len    = (cfg_len == '0) ? BURST_W'(1) : cfg_len;
  assign burst_last = ({1'b0, wrap_cnt} + 1'b1) >= {1'b0, eff_len};
  assign sweep_last = (ftw >= cfg_end);
  // Sum is one bit wider so a step can never wrap past the end word.
  assign ftw_sum    = {1'b0, ftw} + {1'b0, cfg_step};
  assign ftw_next   = (ftw_sum >= {1'b0, cfg_end}) ? cfg_end : ftw_sum[PHASE_W-1:0];
  assign terminate  = wrap && ((cfg_mode == MODE_BURST && burst_last) ||
                               (cfg_mode == MODE_SWEEP && sweep_last));
  assign busy       = (state != ST_IDLE);

`ifdef WAVEGEN_PHASE_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)          lfsr <= LFSR_SEED;
    else if (advance) lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
  end

  // Dither only perturbs the lookup; the accumulator stays exact.
  assign look_phase = phase + {{DATA_W{1'b0}}, lfsr[PHASE_W-DATA_W-1:0]};
`else
  assign look_phase = phase;
`endif

  wave_shape_lut #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_shape (
    .phase_top (look_phase[PHASE_W-1 -: DATA_W]),
    .wave_sel  (cfg_wave),
    .shape     (shape)
  );

  always_comb begin
    product = PROD_W'($signed(shape)) * PROD_W'($signed({1'b0, cfg_amp}));
    scaled  = product >>> 3;
    gained  = DATA_W'(sat_clamp(int'(scaled), DATA_W));
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN:   if (stop || terminate) state_n = ST_DRAIN;
      ST_DRAIN: if (!out_valid) begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_mode  <= MODE_CONT;
      cfg_wave  <= '0;
      cfg_end   <= '0;
      cfg_step  <= '0;
      cfg_len   <= '0;
      cfg_amp   <= '0;
      phase     <= '0;
      ftw       <= '0;
      wrap_cnt  <= '0;
      out_valid <= 1'b0;
      wave_out  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (state == ST_IDLE && start) begin
        cfg_mode <= mode_e'(mode);
        cfg_wave <= wave_sel;
        cfg_end  <= ftw_end;
        cfg_step <= ftw_step;
        cfg_len  <= burst_len;
        cfg_amp  <= amp;
        phase    <= '0;
        ftw      <= ftw_start;
        wrap_cnt <= '0;
      end
      if (advance) begin
        wave_out  <= gained;
        out_valid <= 1'b1;
        phase     <= phase_sum[PHASE_W-1:0];
        if (wrap) begin
          wrap_cnt <= wrap_cnt + 1'b1;
          if (cfg_mode == MODE_SWEEP && !sweep_last) ftw <= ftw_next;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_waveform_gen_dds.sv
// Directed scoreboard bench for waveform_gen_dds: expected samples are queued
// from a behavioural model when a run is started and popped on each accept.
module tb_waveform_gen_dds;

  logic        clk = 1'b0;
  logic        rst, start, stop, sample_en, out_ready;
  logic [1:0]  mode, wave_sel;
  logic [23:0] ftw_start, ftw_end, ftw_step;
  logic [15:0] burst_len;
  logic [3:0]  amp;
  logic        out_valid, busy, done;
  logic [11:0] wave_out;

  typedef struct {
    bit chk;
    int val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   acc_cnt     = 0;
  int   done_cnt    = 0;
  int   cyc         = 0;
  int   last_acc_edge = 0;
  bit   free_run    = 1'b0;

  waveform_gen_dds dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .wave_sel  (wave_sel),
    .ftw_start (ftw_start),
    .ftw_end   (ftw_end),
    .ftw_step  (ftw_step),
    .burst_len (burst_len),
    .amp       (amp),
    .sample_en (sample_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wave_out  (wave_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept monitor: a transfer happens on the edge following this negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        acc_cnt++;
        last_acc_edge = cyc + 1;
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk) begin
            vectors++;
            assert (int'($signed(wave_out)) === e.val) else begin
              miscompares++;
              $error("FAIL sample[%0d]: observed %0d expected %0d", acc_cnt - 1,
                     int'($signed(wave_out)), e.val);
            end
          end
        end else begin
          vectors++;
          assert (free_run) else begin
            miscompares++;
            $error("FAIL extra_sample[%0d]: observed %0d expected none", acc_cnt - 1,
                   int'($signed(wave_out)));
          end
        end
      end
    end
  end

  function automatic int model_shape(input int wave, input longint ph, input int gain);
    int p, s, f, g;
    p = int'((ph >> 12) & 64'hFFF);
    f = (p >= 2048) ? 4095 - p : p;
    case (wave)
      1:       s = (p < 2048) ? 2047 : -2048;
      2:       s = 2 * f - 2048;
      3:       s = p - 2048;
      default: s = 0;
    endcase
    g = (s * gain) >>> 3;
    if (g > 2047)  g = 2047;
    if (g < -2048) g = -2048;
    return g;
  endfunction

  task automatic push_model(input int wave, input int md, input int gain, input longint fs,
                            input longint fe, input longint st, input int len, input int nmax,
                            output int n);
    longint ph, f, s;
    int wraps, eff;
    bit fin;
    exp_t e;
    ph = 0; f = fs; wraps = 0; fin = 0; n = 0;
    eff = (len == 0) ? 1 : len;
    while (!fin && n < nmax) begin
      e.chk = 1'b1;
      e.val = model_shape(wave, ph, gain);
      sb.push_back(e);
      n++;
      s = ph + f;
      if (s >= 64'd16777216) begin
        ph = s - 64'd16777216;
        if (md == 1) begin
          wraps++;
          if (wraps >= eff) fin = 1;
        end else if (md == 2) begin
          if (f >= fe) fin = 1;
          else f = (f + st >= fe) ? fe : f + st;
        end
      end else begin
        ph = s;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int md, input int wv, input int gain, input longint fs,
                           input longint fe, input longint st, input int len, input bit with_stop);
    free_run  = 1'b0;
    acc_cnt   = 0;
    done_cnt  = 0;
    mode      = 2'(md);
    wave_sel  = 2'(wv);
    amp       = 4'(gain);
    ftw_start = 24'(fs);
    ftw_end   = 24'(fe);
    ftw_step  = 24'(st);
    burst_len = 16'(len);
    start     = 1'b1;
    stop      = with_stop;
    tick();
    start     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    free_run = 1'b1;
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, int'(done), 1);
    if (done) check({tag, "_done_latency"}, cyc - last_acc_edge, 1);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_busy_low"}, int'(busy), 0);
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    int n;
    int held;
    exp_t e;

    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_en = 1'b1; out_ready = 1'b1;
    mode = '0; wave_sel = '0; ftw_start = '0; ftw_end = '0; ftw_step = '0;
    burst_len = '0; amp = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wave_out", int'(wave_out), 0);

    // Continuous sine, 256-sample period: quarter points 0/+max/0/-max.
    for (int i = 0; i <= 256; i++) begin
      e.chk = (i % 64 == 0);
      e.val = (i == 64) ? 2047 : (i == 192) ? -2047 : 0;
      sb.push_back(e);
    end
    start_run(0, 0, 8, 65536, 0, 0, 0, 1'b0);
    wait_drain("sine", 600);
    check("sine_no_early_done", done_cnt, 0);
    pulse_stop();
    wait_done("sine", 50);

    // Burst square with start and stop together; config inputs then scrambled.
    push_model(1, 1, 8, 64'd1048576, 0, 0, 3, 1000, n);
    start_run(1, 1, 8, 64'd1048576, 0, 0, 3, 1'b1);
    check("start_wins_busy", int'(busy), 1);
    mode = 2'd0; wave_sel = 2'd3; amp = 4'd1; ftw_start = 24'd7; burst_len = 16'd9;
    wait_done("burst", 200);
    check("burst_count", acc_cnt, n);
    check("burst_sb_empty", sb.size(), 0);

    // Linear sweep 2^18 -> 2^20 in 2^18 steps.
    push_model(1, 2, 8, 64'd262144, 64'd1048576, 64'd262144, 0, 1000, n);
    start_run(2, 1, 8, 64'd262144, 64'd1048576, 64'd262144, 0, 1'b0);
    wait_done("sweep", 400);
    check("sweep_count", acc_cnt, n);
    check("sweep_sb_empty", sb.size(), 0);

    // Sweep with start == end: a single cycle.
    push_model(3, 2, 8, 64'd1048576, 64'd1048576, 64'd262144, 0, 1000, n);
    start_run(2, 3, 8, 64'd1048576, 64'd1048576, 64'd262144, 0, 1'b0);
    wait_done("sweep_eq", 100);
    check("sweep_eq_count", acc_cnt, 16);

    // Backpressure on a continuous triangle.
    push_model(2, 0, 8, 64'd262144, 0, 0, 0, 128, n);
    start_run(0, 2, 8, 64'd262144, 0, 0, 0, 1'b0);
    repeat (30) tick();
    out_ready = 1'b0;
    held = int'(wave_out);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_wave_held", int'(wave_out), held);
      check("stall_valid_held", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_drain("stall", 300);
    pulse_stop();
    wait_done("stall", 50);

    // Sawtooth at amp=15 saturates at both rails.
    push_model(3, 0, 15, 64'd262144, 0, 0, 0, 64, n);
    start_run(0, 3, 15, 64'd262144, 0, 0, 0, 1'b0);
    wait_drain("saw_sat", 200);
    pulse_stop();
    wait_done("saw_sat", 50);

    // amp=0 yields silence.
    for (int i = 0; i < 64; i++) begin
      e.chk = 1'b1;
      e.val = 0;
      sb.push_back(e);
    end
    start_run(0, 3, 0, 64'd262144, 0, 0, 0, 1'b0);
    wait_drain("amp_zero", 200);
    pulse_stop();
    wait_done("amp_zero", 50);

    // Reset in the middle of a long burst.
    push_model(1, 1, 8, 64'd1048576, 0, 0, 100, 2000, n);
    start_run(1, 1, 8, 64'd1048576, 0, 0, 100, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wave_out", int'(wave_out), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    sb.delete();
    done_cnt = 0;
    repeat (8) tick();
    check("rst_no_done", done_cnt, 0);
    check("rst_stays_idle", int'(busy), 0);
    check("rst_no_output", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
